prim_onehot_sel_gen: RTL

PRIM_ONEHOT_SEL_GEN -- requirements
Module: prim_onehot_sel_gen

---
 rtl/prim_onehot_sel_gen.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/prim_onehot_sel_gen.sv
// -----------------------------------------------------------------------------
// prim_onehot_sel_gen
//
// Turns a binary select index into a registered onehot0 select vector with
// break-before-make switching and continuous integrity checking of the
// onehot register.
//
// Parameters
//   AddrWidth    binary select width (>= 1)
//   OneHotWidth  onehot vector width (1 .. 2**AddrWidth)
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        new-select request valid
//   addr_i       requested select index
//   rdy_o        request may be accepted this cycle
//   rel_i        release the current select
//   gnt_o        one-cycle pulse: requested select is now driven
//   oh_o         registered onehot0 select vector
//   addr_o       registered copy of the selected index
//   en_o         registered enable, 1 iff oh_o drives a select
//   range_err_o  one-cycle pulse: out-of-range request rejected
//   fatal_o      sticky integrity error
// -----------------------------------------------------------------------------
module prim_onehot_sel_gen #(
   parameter int AddrWidth   = 5,
   parameter int OneHotWidth = 2**AddrWidth
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_i,
   input  logic [AddrWidth-1:0]   addr_i,
   output logic                   rdy_o,
   input  logic                   rel_i,
   output logic                   gnt_o,
   output logic [OneHotWidth-1:0] oh_o,
   output logic [AddrWidth-1:0]   addr_o,
   output logic                   en_o,
   output logic                   range_err_o,
   output logic                   fatal_o
);

   localparam int NumLeaves = 2**AddrWidth;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StActive = 2'd1;
   localparam logic [1:0] StBreak  = 2'd2;
   localparam logic [1:0] StError  = 2'd3;

   logic [1:0]             state_q;
   logic [OneHotWidth-1:0] oh_q;
   logic [AddrWidth-1:0]   addr_q;
   logic                   en_q;
   logic                   gnt_q;
   logic                   range_err_q;
   logic                   fatal_q;
   logic                   alive_q;

   // Binary index -> onehot, written as a compare loop so that indices at or
   // above OneHotWidth simply produce zero.
   function automatic logic [OneHotWidth-1:0] decode(input logic [AddrWidth-1:0] a);
      logic [OneHotWidth-1:0] v;
      v = '0;
      for (int i = 0; i < OneHotWidth; i++) begin
         if (a == AddrWidth'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Onehot -> binary index by OR-ing the indices of all set bits. Only
   // meaningful when the input is onehot; the multi-bit check covers the rest.
   function automatic logic [AddrWidth-1:0] encode(input logic [OneHotWidth-1:0] v);
      logic [AddrWidth-1:0] idx;
      idx = '0;
      for (int i = 0; i < OneHotWidth; i++) begin
         if (v[i]) idx = idx | AddrWidth'(i);
      end
      return idx;
   endfunction

   // Binary reduction tree. Each level halves the vector in place; a node's
   // "multi" flag is set when both children carry a set bit or either child
   // already saw more than one. Returns {multi, any}.
   function automatic logic [1:0] or_tree(input logic [NumLeaves-1:0] leaves);
      logic [NumLeaves-1:0] any_v;
      logic [NumLeaves-1:0] multi_v;
      any_v   = leaves;
      multi_v = '0;
      for (int w = NumLeaves / 2; w >= 1; w = w / 2) begin
         for (int i = 0; i < w; i++) begin
            multi_v[i] = multi_v[2*i] | multi_v[2*i+1] | (any_v[2*i] & any_v[2*i+1]);
            any_v[i]   = any_v[2*i] | any_v[2*i+1];
         end
      end
      return {multi_v[0], any_v[0]};
   endfunction

   logic [NumLeaves-1:0] oh_pad;
   logic                 oh_any;
   logic                 oh_multi;
   logic                 check_fail;
   logic                 xfer;
   logic                 addr_in_range;

   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      oh_pad                  = '0;
      oh_pad[OneHotWidth-1:0] = oh_q;
      {oh_multi, oh_any}      = or_tree(oh_pad);

      check_fail = 1'b0;
      if (state_q != StError) begin
         check_fail = oh_multi
                    | (oh_any != en_q)
                    | ((state_q == StActive) && (encode(oh_q) != addr_q))
                    | (((state_q == StIdle) || (state_q == StBreak)) && oh_any);
      end
   end

   // alive_q keeps rdy_o low until the first clock edge after reset release.
   assign rdy_o         = alive_q && ((state_q == StIdle) || (state_q == StActive));
   assign xfer          = req_i && rdy_o;
   assign addr_in_range = ({1'b0, addr_i} < (AddrWidth+1)'(OneHotWidth));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         oh_q        <= '0;
         addr_q      <= '0;
         en_q        <= 1'b0;
         gnt_q       <= 1'b0;
         range_err_q <= 1'b0;
         fatal_q     <= 1'b0;
         alive_q     <= 1'b0;
      end else begin
         alive_q     <= 1'b1;
         gnt_q       <= 1'b0;
         range_err_q <= 1'b0;
         if (check_fail) begin
            state_q <= StError;
            oh_q    <= '0;
            en_q    <= 1'b0;
            fatal_q <= 1'b1;
         end else begin
            case (state_q)
               StIdle: begin
                  if (xfer) begin
                     if (!addr_in_range) begin
                        range_err_q <= 1'b1;
                     end else begin
                        state_q <= StActive;
                        oh_q    <= decode(addr_i);
                        addr_q  <= addr_i;
                        en_q    <= 1'b1;
                        gnt_q   <= 1'b1;
                     end
                  end
               end
               StActive: begin
                  // A transfer takes priority over a simultaneous release.
                  if (xfer) begin
                     if (!addr_in_range) begin
                        range_err_q <= 1'b1;
                     end else if (addr_i == addr_q) begin
                        gnt_q <= 1'b1;
                     end else begin
                        state_q <= StBreak;
                        oh_q    <= '0;
                        en_q    <= 1'b0;
                        addr_q  <= addr_i;
                     end
                  end else if (rel_i) begin
                     state_q <= StIdle;
                     oh_q    <= '0;
                     en_q    <= 1'b0;
                  end
               end
               StBreak: begin
                  state_q <= StActive;
                  oh_q    <= decode(addr_q);
                  en_q    <= 1'b1;
                  gnt_q   <= 1'b1;
               end
               default: begin
                  state_q <= StError;
                  oh_q    <= '0;
                  en_q    <= 1'b0;
                  fatal_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign oh_o        = oh_q;
   assign addr_o      = addr_q;
   assign en_o        = en_q;
   assign gnt_o       = gnt_q;
   assign range_err_o = range_err_q;
   assign fatal_o     = fatal_q;

endmodule
